// File: rtl/weight_stream_scheduler.sv
// Weight stream scheduler: drives a latency-pipelined weight ROM and
// turns its output into a valid/ready stream. Reads are issued only
// when a FIFO slot is already reserved for the returning word, so no
// ROM word is dropped or duplicated under backpressure.
`timescale 1ns/1ps
module weight_stream_scheduler #(
  parameter int DATA_WIDTH   = 128,
  parameter int OUT_DEPTH    = 576,
  parameter int ADDR_WIDTH   = $clog2(OUT_DEPTH) + 1,
  parameter int ROM_LATENCY  = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [REPEAT_WIDTH-1:0] repeat_count,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  output logic                    rom_ce,
  input  logic [DATA_WIDTH-1:0]   rom_q,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_out_valid,
  output logic                    data_out_last,
  input  logic                    data_out_ready
);

  localparam int TOT_W = REPEAT_WIDTH + ADDR_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + ROM_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [TOT_W-1:0]         remain_q, remain_d;
  logic                     rom_ce_q, rom_ce_d;
  logic                     zero_done_q, zero_done_d;
  logic [ROM_LATENCY-1:0]   trk_vld_q, trk_vld_d;
  logic [ROM_LATENCY-1:0]   trk_last_q, trk_last_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic [DATA_WIDTH-1:0]    fifo_data_q [FIFO_DEPTH];
  logic                     fifo_last_q [FIFO_DEPTH];

  logic [CNT_W-1:0]         inflight;
  logic                     enq;
  logic                     deq;
  logic                     issue;
  logic                     final_accept;
  logic                     addr_at_end;

  // Next-state logic: credit-gated issue, address/remaining counters,
  // in-flight shift register, FIFO pointers and the IDLE/ISSUE/DRAIN FSM.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      inflight = inflight + CNT_W'(trk_vld_q[i]);
    end
    addr_at_end  = (addr_q == ADDR_WIDTH'(OUT_DEPTH - 1));
    enq          = trk_vld_q[ROM_LATENCY-1];
    deq          = (fifo_cnt_q != '0) && data_out_ready;
    // Occupancy before this cycle's dequeue keeps ready out of the issue path.
    issue        = (state_q == S_ISSUE) && (remain_q != '0) &&
                   ((inflight + fifo_cnt_q) < CNT_W'(FIFO_DEPTH));
    final_accept = (state_q == S_DRAIN) && (inflight == '0) &&
                   (fifo_cnt_q == CNT_W'(1)) && data_out_ready;

    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    zero_done_d = 1'b0;

    trk_vld_d[0]  = issue;
    trk_last_d[0] = addr_at_end;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      trk_vld_d[i]  = trk_vld_q[i-1];
      trk_last_d[i] = trk_last_q[i-1];
    end

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(enq) - CNT_W'(deq);
    if (enq) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (deq) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (repeat_count != '0) begin
            state_d  = S_ISSUE;
            addr_d   = '0;
            remain_d = TOT_W'(repeat_count) * TOT_W'(OUT_DEPTH);
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (issue) begin
          addr_d   = addr_at_end ? '0 : addr_q + ADDR_WIDTH'(1);
          remain_d = remain_q - TOT_W'(1);
          if (remain_q == TOT_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (final_accept) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything: flush tracker and FIFO, back to IDLE.
    if (abort) begin
      state_d     = S_IDLE;
      zero_done_d = 1'b0;
      trk_vld_d   = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      fifo_cnt_d  = '0;
    end

    rom_ce_d = (state_d != S_IDLE);
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      rom_ce_q    <= 1'b0;
      zero_done_q <= 1'b0;
      trk_vld_q   <= '0;
      trk_last_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      rom_ce_q    <= rom_ce_d;
      zero_done_q <= zero_done_d;
      trk_vld_q   <= trk_vld_d;
      trk_last_q  <= trk_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // FIFO storage: data only, validity is carried by the control pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_data_q[wr_ptr_q] <= rom_q;
      fifo_last_q[wr_ptr_q] <= trk_last_q[ROM_LATENCY-1];
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (zero_done_q || final_accept) && !abort;
  assign rom_addr       = addr_q;
  assign rom_ce         = rom_ce_q;
  assign data_out_valid = (fifo_cnt_q != '0);
  // Head word is masked while empty so no stale storage is ever presented.
  assign data_out       = data_out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign data_out_last  = data_out_valid && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_weight_stream_scheduler.sv
// Testbench for weight_stream_scheduler: latency-2 ROM model, scoreboard
// of expected {last, word} beats, directed and random-ready scenarios.
`timescale 1ns/1ps
module tb_weight_stream_scheduler;

  localparam int DW = 128;
  localparam int OD = 4;
  localparam int AW = $clog2(OD) + 1;
  localparam int RL = 2;
  localparam int FD = 4;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [RW-1:0] repeat_count;
  logic          abort;
  logic          busy;
  logic          done;
  logic [AW-1:0] rom_addr;
  logic          rom_ce;
  logic [DW-1:0] rom_q;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_last;
  logic          data_out_ready;

  weight_stream_scheduler #(
    .DATA_WIDTH(DW), .OUT_DEPTH(OD), .ADDR_WIDTH(AW),
    .ROM_LATENCY(RL), .FIFO_DEPTH(FD), .REPEAT_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .repeat_count(repeat_count),
    .abort(abort), .busy(busy), .done(done), .rom_addr(rom_addr),
    .rom_ce(rom_ce), .rom_q(rom_q), .data_out(data_out),
    .data_out_valid(data_out_valid), .data_out_last(data_out_last),
    .data_out_ready(data_out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input int a);
    return DW'(17 * (a + 1));
  endfunction

  // ROM model: registered address, two stages, advances only with ce.
  logic [DW-1:0] rom_s1 = '0;
  logic [DW-1:0] rom_s2 = '0;
  always @(posedge clk) begin
    if (rom_ce) begin
      rom_s1 <= word_of(int'(rom_addr));
      rom_s2 <= rom_s1;
    end
  end
  assign rom_q = rom_s2;

  logic [DW:0] exp_q [$];
  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  int ce_cnt   = 0;
  int max_occ  = 0;

  task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pass(input int reps);
    for (int r = 0; r < reps; r++)
      for (int a = 0; a < OD; a++)
        exp_q.push_back({(a == OD - 1), word_of(a)});
  endtask

  task automatic start_run(input int rc);
    start = 1'b1;
    repeat_count = RW'(rc);
    push_pass(rc);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_timeout"}, (n < bound), 1);
  endtask

  task automatic wait_beats(input int target, input int bound, input string tag);
    int n = 0;
    while (acc_cnt < target && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_beat_wait"}, (n < bound), 1);
  endtask

  // Output monitor: scoreboard pop on every transfer, stall stability.
  initial begin
    logic        prev_stall;
    logic [DW:0] prev_out;
    logic [DW:0] e;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (int'(dut.fifo_cnt_q) > max_occ) max_occ = int'(dut.fifo_cnt_q);
        if (done) done_cnt++;
        if (rom_ce) ce_cnt++;
        if (prev_stall) begin
          chk("stall_valid", data_out_valid, 1);
          chk("stall_word", {data_out_last, data_out}, prev_out);
        end
        if (data_out_valid && data_out_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", {data_out_last, data_out}, '0);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {data_out_last, data_out}, e);
            acc_cnt++;
          end
        end
        prev_stall = data_out_valid && !data_out_ready && !abort;
        prev_out   = {data_out_last, data_out};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b0; start = 1'b0; repeat_count = '0; abort = 1'b0; data_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", data_out_valid, 0);
    chk("rst_last", data_out_last, 0);
    chk("rst_data", data_out, 0);
    chk("rst_ce", rom_ce, 0);
    chk("rst_addr", rom_addr, 0);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Single pass, exact cycle timing.
    done_cnt = 0;
    base = acc_cnt;
    start_run(1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("t1_valid_c%0d", k), data_out_valid, (k >= 4 && k <= 7));
      chk($sformatf("t1_done_c%0d", k), done, (k == 7));
      chk($sformatf("t1_busy_c%0d", k), busy, (k <= 7));
      @(posedge clk); #1;
    end
    chk("t1_beats", acc_cnt - base, 4);
    chk("t1_done_cnt", done_cnt, 1);

    // Repeat three passes with wrap.
    done_cnt = 0;
    base = acc_cnt;
    start_run(3);
    wait_idle(200, "t2");
    chk("t2_beats", acc_cnt - base, 12);
    chk("t2_done_cnt", done_cnt, 1);

    // Backpressure: ready low for cycles 3..12.
    done_cnt = 0;
    max_occ = 0;
    base = acc_cnt;
    start = 1'b1; repeat_count = 1; push_pass(1);
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      data_out_ready = !(k >= 3 && k <= 12);
    end
    wait_idle(200, "t3");
    chk("t3_occ_ok", (max_occ <= FD), 1);
    chk("t3_beats", acc_cnt - base, 4);
    chk("t3_done_cnt", done_cnt, 1);

    // Random ready.
    done_cnt = 0;
    max_occ = 0;
    base = acc_cnt;
    start_run(50);
    begin
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 3000) begin
        data_out_ready = ($urandom_range(0, 1) == 1);
        @(posedge clk); #1;
        n++;
      end
      chk("t4_timeout", (n < 3000), 1);
    end
    data_out_ready = 1'b1;
    chk("t4_beats", acc_cnt - base, 200);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_occ_ok", (max_occ <= FD), 1);

    // Abort at beat 2, then restart.
    done_cnt = 0;
    base = acc_cnt;
    start_run(1);
    wait_beats(base + 2, 50, "t5");
    abort = 1'b1;
    data_out_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t5_valid_after_abort", data_out_valid, 0);
    chk("t5_busy_after_abort", busy, 0);
    chk("t5_no_done", done_cnt, 0);
    @(posedge clk); #1;
    data_out_ready = 1'b1;
    base = acc_cnt;
    start_run(1);
    wait_idle(100, "t5r");
    chk("t5_restart_beats", acc_cnt - base, 4);

    // Asynchronous reset at beat 2, then restart.
    base = acc_cnt;
    start_run(3);
    wait_beats(base + 2, 50, "t6");
    #2 rst = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_valid", data_out_valid, 0);
    chk("t6_last", data_out_last, 0);
    chk("t6_data", data_out, 0);
    chk("t6_ce", rom_ce, 0);
    chk("t6_addr", rom_addr, 0);
    exp_q.delete();
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    base = acc_cnt;
    done_cnt = 0;
    start_run(1);
    wait_idle(100, "t6r");
    chk("t6_restart_beats", acc_cnt - base, 4);
    chk("t6_restart_done", done_cnt, 1);

    // Zero repeat count.
    done_cnt = 0;
    ce_cnt = 0;
    start = 1'b1; repeat_count = '0;
    @(negedge clk);
    chk("t7_done_c0", done, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("t7_done_c1", done, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("t7_done_cnt", done_cnt, 1);
    chk("t7_ce_cnt", ce_cnt, 0);
    chk("t7_busy", busy, 0);

    // Start while busy is ignored.
    done_cnt = 0;
    base = acc_cnt;
    start_run(1);
    start = 1'b1; repeat_count = 3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(100, "t8");
    repeat (5) @(posedge clk);
    #1;
    chk("t8_beats", acc_cnt - base, 4);
    chk("t8_done_cnt", done_cnt, 1);
    chk("t8_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
